// File: rtl/ram_fifo_ctrl_if.sv
// Bus between the FIFO sequencing controller, its upstream/downstream users and the
// dual-port RAM it drives.
interface ram_fifo_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              clear_req;
    logic              push_valid;
    logic              push_ready;
    logic [WIDTH-1:0]  push_data;
    logic              pop_en;
    logic              pop_valid;
    logic [WIDTH-1:0]  pop_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [WIDTH-1:0]  ram_d_in;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [WIDTH-1:0]  ram_d_out;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              overflow_err;
    logic              underflow_err;

    modport slave (
        input  clear_req, push_valid, push_data, pop_en, ram_d_out,
        output push_ready, pop_valid, pop_data, ram_we, ram_wr_addr, ram_d_in,
               ram_re, ram_rd_addr, full, empty, count, busy, overflow_err, underflow_err
    );

    modport master (
        output clear_req, push_valid, push_data, pop_en, ram_d_out,
        input  push_ready, pop_valid, pop_data, ram_we, ram_wr_addr, ram_d_in,
               ram_re, ram_rd_addr, full, empty, count, busy, overflow_err, underflow_err
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Sequencing controller turning a registered-read dual-port RAM into a synchronous FIFO,
// with a zero-fill clear sequence after reset or on request.
module ram_fifo_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic in_run, full, empty, push_ready, push_acc, pop_acc;

    assign in_run     = (state_q == RUN);
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    // Readiness comes from start-of-cycle occupancy, so a pop never frees room for a same-cycle push.
    assign push_ready = in_run & ~full;
    assign push_acc   = bus.push_valid & push_ready;
    assign pop_acc    = in_run & bus.pop_en & ~empty;

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        clr_addr_d      = clr_addr_q;
        count_d         = count_q;
        pop_valid_d     = 1'b0;
        ovf_d           = ovf_q;
        udf_d           = udf_q;
        bus.ram_we      = 1'b0;
        bus.ram_wr_addr = wr_ptr_q;
        bus.ram_d_in    = bus.push_data;
        case (state_q)
            IDLE: state_d = CLEAR;
            CLEAR: begin
                bus.ram_we      = 1'b1;
                bus.ram_wr_addr = clr_addr_q;
                bus.ram_d_in    = WIDTH'(0);
                clr_addr_d      = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST) state_d = RUN;
            end
            RUN: begin
                bus.ram_we  = push_acc;
                pop_valid_d = pop_acc;
                if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
                if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
                else if (!push_acc && pop_acc) count_d = count_q - 1'b1;
                if (bus.push_valid && full) ovf_d = 1'b1;
                if (bus.pop_en && empty)    udf_d = 1'b1;
                // A clear discards everything, including whatever was handshaken this cycle.
                if (bus.clear_req) begin
                    state_d     = CLEAR;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    clr_addr_d  = '0;
                    count_d     = '0;
                    pop_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    udf_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            clr_addr_q  <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            clr_addr_q  <= clr_addr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.push_ready    = push_ready;
    assign bus.ram_re        = pop_acc;
    assign bus.ram_rd_addr   = rd_ptr_q;
    assign bus.pop_valid     = pop_valid_q;
    assign bus.pop_data      = bus.ram_d_out;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = count_q;
    assign bus.busy          = ~in_run;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_ram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.WIDTH(16), .ADDR_W(3)) bus ();
    ram_fifo_ctrl #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Registered-read RAM
    logic [15:0] mem [8];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_d_in;
        if (bus.ram_re) rd_q <= mem[bus.ram_rd_addr];
    end
    assign bus.ram_d_out = rd_q;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=clear 2=run
    int          m_mode = 0;
    int          m_clr  = 0;
    int          m_wp   = 0;
    int          m_rp   = 0;
    logic [15:0] m_q[$];
    bit          m_ovf = 0, m_udf = 0, m_pv = 0;
    logic [15:0] m_pd = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_clr = 0; m_wp = 0; m_rp = 0;
            m_q.delete(); m_ovf = 0; m_udf = 0; m_pv = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_clr = 0; m_pv = 0; end
                1: begin
                    m_pv = 0;
                    m_clr++;
                    if (m_clr == 8) begin m_mode = 2; m_clr = 0; end
                end
                default: begin
                    automatic int  sz = m_q.size();
                    automatic bit  pa = bus.push_valid && sz < 8;
                    automatic bit  po = bus.pop_en && sz > 0;
                    if (bus.push_valid && sz == 8) m_ovf = 1;
                    if (bus.pop_en && sz == 0)     m_udf = 1;
                    m_pv = po;
                    if (po) begin m_pd = m_q.pop_front(); m_rp = (m_rp + 1) % 8; end
                    if (pa) begin m_q.push_back(bus.push_data); m_wp = (m_wp + 1) % 8; end
                    if (bus.clear_req) begin
                        m_mode = 1; m_clr = 0; m_wp = 0; m_rp = 0;
                        m_q.delete(); m_ovf = 0; m_udf = 0; m_pv = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare, after inputs have settled following the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            automatic int sz;
            automatic bit pr, we, re;
            #2;
            sz = m_q.size();
            pr = (m_mode == 2) && sz < 8;
            we = (m_mode == 1) || (m_mode == 2 && bus.push_valid && pr);
            re = (m_mode == 2) && bus.pop_en && sz > 0;
            chk("busy", bus.busy, m_mode != 2);
            chk("count", bus.count, sz);
            chk("empty", bus.empty, sz == 0);
            chk("full", bus.full, sz == 8);
            chk("push_ready", bus.push_ready, pr);
            chk("ram_we", bus.ram_we, we);
            chk("ram_re", bus.ram_re, re);
            chk("pop_valid", bus.pop_valid, m_pv);
            chk("overflow_err", bus.overflow_err, m_ovf);
            chk("underflow_err", bus.underflow_err, m_udf);
            if (we) begin
                chk("ram_wr_addr", bus.ram_wr_addr, (m_mode == 1) ? m_clr : m_wp);
                chk("ram_d_in", bus.ram_d_in, (m_mode == 1) ? 16'h0 : bus.push_data);
            end
            if (re) chk("ram_rd_addr", bus.ram_rd_addr, m_rp);
            if (m_pv) chk("pop_data", bus.pop_data, m_pd);
        end
    end

    // One cycle: drive at the falling edge, then settle for literal checks
    task automatic cyc(input bit pv, input logic [15:0] pd, input bit pe, input bit cr);
        @(negedge clk);
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_en     = pe;
        bus.clear_req  = cr;
        #3;
    endtask

    int wa[6] = '{5, 6, 7, 0, 1, 2};

    initial begin
        bus.push_valid = 0; bus.push_data = '0; bus.pop_en = 0; bus.clear_req = 0;
        #1 rst = 1'b0;
        chk_on = 1'b1;
        cyc(0, 0, 0, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_push_ready", bus.push_ready, 0);

        // Release: one idle cycle, then eight zero writes
        @(negedge clk); rst = 1'b1; #3;
        chk("idle_we", bus.ram_we, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            chk("clr_we", bus.ram_we, 1);
            chk("clr_addr", bus.ram_wr_addr, i);
            chk("clr_data", bus.ram_d_in, 0);
        end
        cyc(0, 0, 0, 0);
        chk("run_busy", bus.busy, 0);
        chk("run_count", bus.count, 0);

        // Fill, then one refused push
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'h1000 + 16'(i), 0, 0);
            chk("fill_addr", bus.ram_wr_addr, i);
        end
        cyc(1, 16'h1008, 0, 0);
        chk("full_count", bus.count, 8);
        chk("full_ready", bus.push_ready, 0);
        chk("full_no_we", bus.ram_we, 0);
        cyc(0, 0, 0, 0);
        chk("ovf_set", bus.overflow_err, 1);

        // Drain in order, then one refused pop
        for (int i = 0; i <= 8; i++) begin
            cyc(0, 0, 1, 0);
            if (i > 0) chk("drain_data", bus.pop_data, 16'h1000 + 16'(i - 1));
        end
        chk("drain_empty", bus.empty, 1);
        cyc(0, 0, 0, 0);
        chk("udf_set", bus.underflow_err, 1);

        // Wrap the pointers
        for (int i = 0; i < 5; i++) cyc(1, 16'h2000 + 16'(i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 16'h00A0 + 16'(i), 0, 0);
            chk("wrap_addr", bus.ram_wr_addr, wa[i]);
        end
        for (int i = 0; i <= 6; i++) begin
            cyc(0, 0, i < 6, 0);
            if (i > 0) chk("wrap_data", bus.pop_data, 16'h00A0 + 16'(i - 1));
        end

        // Concurrent push/pop at count 3, then at full
        for (int i = 0; i < 3; i++) cyc(1, 16'h00B0 + 16'(i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'h00C0 + 16'(i), 1, 0);
        cyc(0, 0, 0, 0);
        chk("conc_count", bus.count, 3);
        for (int i = 0; i < 5; i++) cyc(1, 16'h00D0 + 16'(i), 0, 0);
        cyc(1, 16'h00EE, 1, 0);
        chk("fullpp_we", bus.ram_we, 0);
        chk("fullpp_re", bus.ram_re, 1);
        cyc(0, 0, 0, 0);
        chk("fullpp_count", bus.count, 7);
        chk("fullpp_ovf", bus.overflow_err, 1);

        // Clear mid-run with count 4 and overflow set
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("preclr_count", bus.count, 4);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("mclr_addr", bus.ram_wr_addr, i);
            chk("mclr_count", bus.count, 0);
            chk("mclr_ovf", bus.overflow_err, 0);
        end
        // Reset at clear step 3, sequence restarts at address 0
        @(negedge clk); rst = 1'b0; #3;
        chk("mrst_we", bus.ram_we, 0);
        @(negedge clk); rst = 1'b1; #3;
        chk("mrst_idle_we", bus.ram_we, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            chk("rclr_addr", bus.ram_wr_addr, i);
        end
        cyc(1, 16'h0055, 0, 0);
        chk("post_busy", bus.busy, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("post_data", bus.pop_data, 16'h0055);
        cyc(0, 0, 0, 0);
        chk_on = 1'b0;
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
